// File: rtl/complete_buffer_pkg.sv
// Shared definitions for the completion buffer: source/completion widths,
// the stored entry layout, and the source index map (ALU0..2, then LSU).
// Ports: none (package).
package complete_buffer_pkg;

    localparam int XLEN      = 32;
    localparam int PREG_W    = 6;
    localparam int NUM_SRC   = 4;
    localparam int CMP_WIDTH = 2;

    localparam int SRC_ALU0 = 0;
    localparam int SRC_ALU1 = 1;
    localparam int SRC_ALU2 = 2;
    localparam int SRC_LSU  = 3;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   data;
        logic [PREG_W-1:0] preg;
        logic              wr_en;
        logic              is_store;
    } cmp_entry_t;

endpackage

// File: rtl/complete_buffer_if.sv
// Bundle between the functional units / ROB (master) and the completion buffer (slave).
// Ports: flush, src_* result slots packed per source, rob_ready,
//        cmp_* completion slots packed per lane, src_ready, occupancy.
interface complete_buffer_if
    import complete_buffer_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                        flush;
    logic [NUM_SRC-1:0]          src_valid;
    logic                        src_ready;
    logic [NUM_SRC*XLEN-1:0]     src_pc;
    logic [NUM_SRC*XLEN-1:0]     src_data;
    logic [NUM_SRC*PREG_W-1:0]   src_preg;
    logic [NUM_SRC-1:0]          src_wr_en;
    logic [NUM_SRC-1:0]          src_is_store;
    logic                        rob_ready;
    logic [CMP_WIDTH-1:0]        cmp_valid;
    logic [CMP_WIDTH*XLEN-1:0]   cmp_pc;
    logic [CMP_WIDTH*XLEN-1:0]   cmp_data;
    logic [CMP_WIDTH*PREG_W-1:0] cmp_preg;
    logic [CMP_WIDTH-1:0]        cmp_wr_en;
    logic [CMP_WIDTH-1:0]        cmp_is_store;
    logic [OCC_W-1:0]            occupancy;

    modport master (
        output flush, src_valid, src_pc, src_data, src_preg, src_wr_en, src_is_store, rob_ready,
        input  src_ready, cmp_valid, cmp_pc, cmp_data, cmp_preg, cmp_wr_en, cmp_is_store, occupancy
    );

    modport slave (
        input  flush, src_valid, src_pc, src_data, src_preg, src_wr_en, src_is_store, rob_ready,
        output src_ready, cmp_valid, cmp_pc, cmp_data, cmp_preg, cmp_wr_en, cmp_is_store, occupancy
    );

endinterface

// File: rtl/complete_buffer.sv
// Completion buffer: queues up to NUM_SRC FU results per cycle in arrival order, presents CMP_WIDTH to the ROB/wakeup.
// Latency: result accepted at edge N is visible on cmp_* in cycle N+1; outputs come from registered state only.
// Backpressure: src_ready is all-or-nothing, high while at least NUM_SRC entries are free; ROB takes all valid lanes or none.
// Ports: clk, rstn (async active-low), bus (complete_buffer_if.slave: src_*, flush, rob_ready in; cmp_*, src_ready, occupancy out).
module complete_buffer
    import complete_buffer_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic             clk,
    input  logic             rstn,
    complete_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    cmp_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic             accept;
    logic [OCC_W-1:0] enq;
    logic [OCC_W-1:0] deq;
    logic [PTR_W-1:0] wr_idx  [NUM_SRC];
    cmp_entry_t       src_ent [NUM_SRC];

    // Ready looks only at the registered count so the FUs never see a path
    // from this cycle's ROB drain.
    assign bus.src_ready = (count_q <= OCC_W'(DEPTH - NUM_SRC));
    assign accept        = bus.src_ready && !bus.flush;
    assign bus.occupancy = count_q;

    // Compact the valid sources onto consecutive tail slots: each source's
    // slot is tail plus the number of valid lower-indexed sources.
    always_comb begin
        enq = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            wr_idx[i]           = tail_q + PTR_W'(enq);
            src_ent[i].pc       = bus.src_pc[i*XLEN +: XLEN];
            src_ent[i].data     = bus.src_data[i*XLEN +: XLEN];
            src_ent[i].preg     = bus.src_preg[i*PREG_W +: PREG_W];
            src_ent[i].wr_en    = bus.src_wr_en[i];
            src_ent[i].is_store = bus.src_is_store[i];
            if (bus.src_valid[i]) begin
                enq = enq + OCC_W'(1);
            end
        end
    end

    always_comb begin
        deq = '0;
        if (bus.rob_ready) begin
            deq = (count_q > OCC_W'(CMP_WIDTH)) ? OCC_W'(CMP_WIDTH) : count_q;
        end
        head_d  = head_q + PTR_W'(deq);
        tail_d  = accept ? (tail_q + PTR_W'(enq)) : tail_q;
        count_d = count_q + (accept ? enq : '0) - deq;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: a slot is only ever shown after it has
    // been written, and empty lanes are forced to zero below.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_valid[i]) begin
                    mem_q[wr_idx[i]] <= src_ent[i];
                end
            end
        end
    end

    always_comb begin
        cmp_entry_t rd_ent;
        bus.cmp_valid    = '0;
        bus.cmp_pc       = '0;
        bus.cmp_data     = '0;
        bus.cmp_preg     = '0;
        bus.cmp_wr_en    = '0;
        bus.cmp_is_store = '0;
        for (int k = 0; k < CMP_WIDTH; k++) begin
            rd_ent = mem_q[head_q + PTR_W'(k)];
            if (count_q > OCC_W'(k)) begin
                bus.cmp_valid[k]                  = 1'b1;
                bus.cmp_pc[k*XLEN +: XLEN]        = rd_ent.pc;
                bus.cmp_data[k*XLEN +: XLEN]      = rd_ent.data;
                bus.cmp_preg[k*PREG_W +: PREG_W]  = rd_ent.preg;
                bus.cmp_wr_en[k]                  = rd_ent.wr_en;
                bus.cmp_is_store[k]               = rd_ent.is_store;
            end
        end
    end

endmodule

// File: tb/tb_complete_buffer.sv
module tb_complete_buffer;
    import complete_buffer_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [5:0]  preg;
        logic        we;
        logic        st;
    } ent_t;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    logic [31:0] pc_a   [4];
    logic [31:0] data_a [4];
    logic [5:0]  preg_a [4];
    logic        we_a   [4];
    logic        st_a   [4];

    ent_t mq[$];

    complete_buffer_if #(.DEPTH(8)) bus ();

    complete_buffer #(.DEPTH(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [31:0] pc, input logic [31:0] d,
                           input logic [5:0] p, input logic we, input logic st);
        pc_a[i] = pc; data_a[i] = d; preg_a[i] = p; we_a[i] = we; st_a[i] = st;
    endtask

    task automatic drive(input logic [3:0] v, input logic rr, input logic fl);
        bus.src_valid = v;
        bus.rob_ready = rr;
        bus.flush     = fl;
        for (int i = 0; i < 4; i++) begin
            bus.src_pc[i*32 +: 32]  = pc_a[i];
            bus.src_data[i*32 +: 32] = data_a[i];
            bus.src_preg[i*6 +: 6]  = preg_a[i];
            bus.src_wr_en[i]        = we_a[i];
            bus.src_is_store[i]     = st_a[i];
        end
    endtask

    // Compare every output against the head of the reference queue.
    task automatic check_outputs(input string t);
        ent_t e;
        for (int k = 0; k < 2; k++) begin
            if (k < mq.size()) begin
                e = mq[k];
                chk($sformatf("%s_vld%0d", t, k), 64'(bus.cmp_valid[k]), 64'd1);
                chk($sformatf("%s_pc%0d", t, k), 64'(bus.cmp_pc[k*32 +: 32]), 64'(e.pc));
                if (!e.st)
                    chk($sformatf("%s_data%0d", t, k), 64'(bus.cmp_data[k*32 +: 32]), 64'(e.data));
                chk($sformatf("%s_preg%0d", t, k), 64'(bus.cmp_preg[k*6 +: 6]), 64'(e.preg));
                chk($sformatf("%s_we%0d", t, k), 64'(bus.cmp_wr_en[k]), 64'(e.we));
                chk($sformatf("%s_st%0d", t, k), 64'(bus.cmp_is_store[k]), 64'(e.st));
            end else begin
                chk($sformatf("%s_vld%0d", t, k), 64'(bus.cmp_valid[k]), 64'd0);
                chk($sformatf("%s_zero%0d", t, k),
                    64'({bus.cmp_pc[k*32 +: 32] | bus.cmp_data[k*32 +: 32]}) |
                    64'({bus.cmp_preg[k*6 +: 6], bus.cmp_wr_en[k], bus.cmp_is_store[k]}), 64'd0);
            end
        end
        chk($sformatf("%s_occ", t), 64'(bus.occupancy), 64'(mq.size()));
        chk($sformatf("%s_rdy", t), 64'(bus.src_ready), 64'((8 - mq.size()) >= 4));
    endtask

    // One clock: check current outputs, apply inputs, advance the model, step.
    task automatic cycle(input string t, input logic [3:0] v, input logic rr, input logic fl);
        int   deq;
        bit   rdy;
        ent_t tmp;
        check_outputs(t);
        drive(v, rr, fl);
        rdy = (8 - mq.size()) >= 4;
        if (fl) begin
            mq.delete();
        end else begin
            deq = rr ? ((mq.size() < 2) ? mq.size() : 2) : 0;
            repeat (deq) tmp = mq.pop_front();
            if (rdy) begin
                for (int i = 0; i < 4; i++) begin
                    if (v[i]) begin
                        tmp.pc = pc_a[i]; tmp.data = data_a[i]; tmp.preg = preg_a[i];
                        tmp.we = we_a[i]; tmp.st = st_a[i];
                        mq.push_back(tmp);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(4'h0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_occ", 64'(bus.occupancy), 64'd0);
        chk("arst_vld", 64'(bus.cmp_valid), 64'd0);
        mq.delete();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [3:0] v;
        bit         rr, fl;
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        drive(4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        check_outputs("rst");
        rstn = 1'b1;
        @(negedge clk);

        // Single ALU1 result, drained by the ROB the cycle it appears
        set_src(SRC_ALU1, 32'h10, 32'h5, 6'd7, 1'b1, 1'b0);
        cycle("t1a", 4'b0010, 1'b1, 1'b0);
        chk("t1_vld", 64'(bus.cmp_valid), 64'b01);
        chk("t1_pc", 64'(bus.cmp_pc[31:0]), 64'h10);
        chk("t1_data", 64'(bus.cmp_data[31:0]), 64'h5);
        chk("t1_preg", 64'(bus.cmp_preg[5:0]), 64'd7);
        cycle("t1b", 4'b0000, 1'b1, 1'b0);
        chk("t1_occ0", 64'(bus.occupancy), 64'd0);

        // Fill to full with all four sources, ROB stalled
        for (int i = 0; i < 4; i++) set_src(i, 32'h20 + 32'(4*i), $urandom, 6'(10 + i), 1'b1, 1'b0);
        cycle("t2a", 4'hF, 1'b0, 1'b0);
        chk("t2_occ4", 64'(bus.occupancy), 64'd4);
        chk("t2_rdy4", 64'(bus.src_ready), 64'd1);
        for (int i = 0; i < 4; i++) set_src(i, 32'h30 + 32'(4*i), $urandom, 6'(20 + i), 1'b1, 1'b0);
        cycle("t2b", 4'hF, 1'b0, 1'b0);
        chk("t2_occ8", 64'(bus.occupancy), 64'd8);
        chk("t2_rdy8", 64'(bus.src_ready), 64'd0);
        // Sources hold while not ready; nothing may be taken
        cycle("t2c", 4'hF, 1'b0, 1'b0);
        chk("t2_hold", 64'(bus.occupancy), 64'd8);

        // Drain in pairs with sources still holding
        cycle("t3a", 4'hF, 1'b1, 1'b0);
        chk("t3_pc0", 64'(bus.cmp_pc[31:0]), 64'h28);
        chk("t3_pc1", 64'(bus.cmp_pc[63:32]), 64'h2C);
        cycle("t3b", 4'hF, 1'b1, 1'b0);
        chk("t3_occ4", 64'(bus.occupancy), 64'd4);
        chk("t3_rdy", 64'(bus.src_ready), 64'd1);
        cycle("t3c", 4'hF, 1'b1, 1'b0);
        chk("t3_occ6", 64'(bus.occupancy), 64'd6);
        repeat (4) cycle("t3d", 4'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation
        set_src(0, 32'h77, 32'h1, 6'd1, 1'b1, 1'b0);
        cycle("rs", 4'h1, 1'b0, 1'b0);
        do_reset();

        // Wrap-around: advance head to 6, then straddle index 7 -> 0
        for (int j = 0; j < 6; j++) begin
            set_src(0, 32'h100 + 32'(4*j), $urandom, 6'(j), 1'b1, 1'b0);
            cycle("wr_a", 4'h1, 1'b1, 1'b0);
        end
        cycle("wr_b", 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) set_src(i, 32'h200 + 32'(4*i), $urandom, 6'(30 + i), 1'b1, 1'b0);
        cycle("wr_c", 4'hF, 1'b0, 1'b0);
        chk("wr_pc0", 64'(bus.cmp_pc[31:0]), 64'h200);
        chk("wr_pc1", 64'(bus.cmp_pc[63:32]), 64'h204);
        cycle("wr_d", 4'h0, 1'b1, 1'b0);
        chk("wr_pc2", 64'(bus.cmp_pc[31:0]), 64'h208);
        chk("wr_pc3", 64'(bus.cmp_pc[63:32]), 64'h20C);
        cycle("wr_e", 4'h0, 1'b1, 1'b0);

        // LSU store completion
        set_src(SRC_LSU, 32'h300, $urandom, 6'd9, 1'b0, 1'b1);
        cycle("st_a", 4'b1000, 1'b1, 1'b0);
        chk("st_is", 64'(bus.cmp_is_store[0]), 64'd1);
        chk("st_we", 64'(bus.cmp_wr_en[0]), 64'd0);
        cycle("st_b", 4'h0, 1'b1, 1'b0);

        // Flush at occupancy 5 with three sources valid
        for (int i = 0; i < 4; i++) set_src(i, 32'h400 + 32'(4*i), $urandom, 6'(40 + i), 1'b1, 1'b0);
        cycle("fl_a", 4'hF, 1'b0, 1'b0);
        cycle("fl_b", 4'h1, 1'b0, 1'b0);
        chk("fl_occ5", 64'(bus.occupancy), 64'd5);
        for (int i = 0; i < 4; i++) set_src(i, 32'h500 + 32'(4*i), $urandom, 6'(50 + i), 1'b1, 1'b0);
        cycle("fl_c", 4'b0111, 1'b1, 1'b1);
        chk("fl_occ0", 64'(bus.occupancy), 64'd0);
        chk("fl_vld0", 64'(bus.cmp_valid), 64'd0);
        chk("fl_rdy", 64'(bus.src_ready), 64'd1);
        repeat (2) cycle("fl_d", 4'h0, 1'b1, 1'b0);

        // Randomized traffic; sources hold their results while not ready
        v = 4'h0;
        for (int n = 0; n < 400; n++) begin
            if (v == 4'h0 || mq.size() <= 4) begin
                v = 4'($urandom_range(0, 15));
                for (int i = 0; i < 4; i++)
                    set_src(i, $urandom, $urandom, 6'($urandom), 1'($urandom), 1'($urandom));
            end
            rr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 31) == 0);
            cycle("rnd", v, rr, fl);
            if (fl) v = 4'h0;
        end
        repeat (4) cycle("end", 4'h0, 1'b1, 1'b0);
        check_outputs("fin");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
